// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DONE,
        ST_BRK_WAIT
    } state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Line synchroniser, falling-edge detect, bit-timing counter and 3-sample
// majority vote around mid-bit.
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Rx_Serial,
    input  logic i_run,
    output logic o_rx_s,
    output logic o_sync_ok,
    output logic o_fall,
    output logic o_vote_valid,
    output logic o_vote
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int M  = (CLKS_PER_BIT - 1) / 2;
    localparam logic [CW-1:0] C_WRAP = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_S0   = CW'(M - 1);
    localparam logic [CW-1:0] C_S1   = CW'(M);
    localparam logic [CW-1:0] C_S2   = CW'(M + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_prev;
    logic [1:0]    r_fill;
    logic [CW-1:0] r_cnt;
    logic          r_s0;
    logic          r_s1;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_fill  <= 2'b00;
            r_cnt   <= '0;
            r_s0    <= 1'b0;
            r_s1    <= 1'b0;
        end else begin
            r_sync1 <= i_Rx_Serial;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            // r_fill tracks when the reset value has been flushed out of the sync chain
            r_fill  <= {r_fill[0], 1'b1};
            if (!i_run || r_cnt == C_WRAP) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (i_run && r_cnt == C_S0) r_s0 <= r_sync2;
            if (i_run && r_cnt == C_S1) r_s1 <= r_sync2;
        end
    end

    assign o_rx_s       = r_sync2;
    assign o_sync_ok    = r_fill[1];
    assign o_fall       = r_prev & ~r_sync2;
    assign o_vote_valid = i_run && (r_cnt == C_S2);
    assign o_vote       = maj3(r_s0, r_s1, r_sync2);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: frame FSM, data shift register, parity and
// framing checks, break detection and registered result outputs.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Data,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Busy
);

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic       ODD_PAR   = (PARITY == PARITY_ODD);

    state_t               r_state;
    logic                 r_armed;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic                 r_frame_err;
    logic                 r_all_zero;
    logic                 r_dv;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_brk;

    logic w_rx_s;
    logic w_sync_ok;
    logic w_fall;
    logic w_vote_valid;
    logic w_vote;
    logic w_run;
    logic w_frame_err_next;

    assign w_run = (r_state == ST_START) || (r_state == ST_DATA) ||
                   (r_state == ST_PARITY) || (r_state == ST_STOP);

    uart_bit_sampler #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_sampler (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_Rx_Serial (i_Rx_Serial),
        .i_run       (w_run),
        .o_rx_s      (w_rx_s),
        .o_sync_ok   (w_sync_ok),
        .o_fall      (w_fall),
        .o_vote_valid(w_vote_valid),
        .o_vote      (w_vote)
    );

    assign w_frame_err_next = r_frame_err | ~w_vote;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state     <= ST_IDLE;
            r_armed     <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_all_zero  <= 1'b0;
            r_dv        <= 1'b0;
            r_data      <= '0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_brk       <= 1'b0;
        end else begin
            r_dv <= 1'b0;
            if (w_sync_ok && w_rx_s) r_armed <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (r_armed && w_fall) begin
                        r_state     <= ST_START;
                        r_bit_cnt   <= '0;
                        r_par_err   <= 1'b0;
                        r_frame_err <= 1'b0;
                        r_all_zero  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_vote_valid) r_state <= w_vote ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (w_vote_valid) begin
                        r_shift    <= {w_vote, r_shift[DATA_BITS-1:1]};
                        r_all_zero <= r_all_zero & ~w_vote;
                        if (r_bit_cnt == LAST_DATA) begin
                            r_bit_cnt <= '0;
                            r_state   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_vote_valid) begin
                        r_par_err  <= w_vote ^ (^r_shift) ^ ODD_PAR;
                        r_all_zero <= r_all_zero & ~w_vote;
                        r_state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_vote_valid) begin
                        r_frame_err <= w_frame_err_next;
                        if (r_bit_cnt == LAST_STOP) begin
                            // Results are loaded together so they line up with the strobe
                            r_state <= ST_DONE;
                            r_dv    <= 1'b1;
                            r_data  <= r_shift;
                            r_perr  <= r_par_err;
                            r_ferr  <= w_frame_err_next;
                            r_brk   <= r_all_zero & w_frame_err_next;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= r_brk ? ST_BRK_WAIT : ST_IDLE;
                end
                ST_BRK_WAIT: begin
                    if (w_rx_s) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_Rx_DV      = r_dv;
    assign o_Rx_Data    = r_data;
    assign o_Parity_Err = r_perr & (PARITY != PARITY_NONE);
    assign o_Frame_Err  = r_ferr;
    assign o_Break      = r_brk;
    assign o_Busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: four receiver configurations (8N1, 8E1,
// 8N2, 9O1) fed directed and random frames; a monitor checks every strobe.
module tb_uart_rx_cfg;

    localparam int CPB = 16;
    localparam int M   = (CPB - 1) / 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_line [4];
    logic       dv      [4];
    logic       pe      [4];
    logic       fe      [4];
    logic       brk     [4];
    logic       busy    [4];
    logic [7:0] data0, data1, data2;
    logic [8:0] data3;

    longint cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int         k;
        logic [8:0] data;
        logic       pe;
        logic       fe;
        logic       brk;
        longint     cyc;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_line[0]), .o_Rx_DV(dv[0]),
        .o_Rx_Data(data0), .o_Parity_Err(pe[0]), .o_Frame_Err(fe[0]), .o_Break(brk[0]),
        .o_Busy(busy[0]));
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_line[1]), .o_Rx_DV(dv[1]),
        .o_Rx_Data(data1), .o_Parity_Err(pe[1]), .o_Frame_Err(fe[1]), .o_Break(brk[1]),
        .o_Busy(busy[1]));
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_line[2]), .o_Rx_DV(dv[2]),
        .o_Rx_Data(data2), .o_Parity_Err(pe[2]), .o_Frame_Err(fe[2]), .o_Break(brk[2]),
        .o_Busy(busy[2]));
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY(2), .STOP_BITS(1)) u_9o1 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_line[3]), .o_Rx_DV(dv[3]),
        .o_Rx_Data(data3), .o_Parity_Err(pe[3]), .o_Frame_Err(fe[3]), .o_Break(brk[3]),
        .o_Busy(busy[3]));

    function automatic int cfg_db(input int k);
        return (k == 3) ? 9 : 8;
    endfunction

    function automatic int cfg_par(input int k);
        return (k == 1) ? 1 : ((k == 3) ? 2 : 0);
    endfunction

    function automatic int cfg_stop(input int k);
        return (k == 2) ? 2 : 1;
    endfunction

    function automatic logic [8:0] get_data(input int k);
        case (k)
            0:       return {1'b0, data0};
            1:       return {1'b0, data1};
            2:       return {1'b0, data2};
            default: return data3;
        endcase
    endfunction

    // Strobe latency from the clock edge the start bit is driven after:
    // two sync flops plus the start-detect register, then N*CPB+M+2.
    function automatic longint exp_cycle(input longint t0, input int nbits);
        return t0 + longint'((nbits - 1) * CPB + M + 2 + 3);
    endfunction

    task automatic check(input string name, input longint got, input longint want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end else begin
            $display("ok   %s = %0d", name, got);
        end
    endtask

    task automatic hold_line(input int k, input logic v, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1 rx_line[k] = v;
        end
    endtask

    task automatic send_frame(input int k, input logic [8:0] data, input bit par_flip,
                              input logic [1:0] stop_mask, input logic [8:0] flip_mask,
                              input int gap_bits);
        int         db;
        int         p;
        int         s;
        logic       bits  [$];
        logic       flips [$];
        logic [8:0] d;
        logic       pbit;
        logic       stop_zero;
        exp_t       e;
        db = cfg_db(k);
        p  = cfg_par(k);
        s  = cfg_stop(k);
        d  = data & ((9'd1 << db) - 9'd1);
        bits.push_back(1'b0);
        flips.push_back(1'b0);
        for (int i = 0; i < db; i++) begin
            bits.push_back(d[i]);
            flips.push_back(flip_mask[i]);
        end
        pbit = (^d) ^ (p == 2) ^ par_flip;
        if (p != 0) begin
            bits.push_back(pbit);
            flips.push_back(1'b0);
        end
        stop_zero = 1'b0;
        for (int i = 0; i < s; i++) begin
            bits.push_back(~stop_mask[i]);
            flips.push_back(1'b0);
            if (stop_mask[i]) stop_zero = 1'b1;
        end
        e.k    = k;
        e.data = d;
        e.pe   = (p != 0) && par_flip;
        e.fe   = stop_zero;
        e.brk  = (d == 9'd0) && (p == 0 || pbit == 1'b0) && stop_zero;
        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c < CPB; c++) begin
                @(posedge clk);
                #1;
                if (b == 0 && c == 0) begin
                    e.cyc = exp_cycle(cyc, bits.size());
                    exp_q.push_back(e);
                end
                rx_line[k] = (flips[b] && c == M + 1) ? ~bits[b] : bits[b];
            end
        end
        hold_line(k, 1'b1, gap_bits * CPB);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                if (dv[k]) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_strobe dut%0d data=%h pe=%0b fe=%0b brk=%0b cyc=%0d",
                                 k, get_data(k), pe[k], fe[k], brk[k], cyc);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        if (e.k != k || get_data(k) != e.data || pe[k] != e.pe ||
                            fe[k] != e.fe || brk[k] != e.brk || cyc != e.cyc) begin
                            n_err++;
                            $display("FAIL frame dut%0d got data=%h pe=%0b fe=%0b brk=%0b cyc=%0d, want dut%0d data=%h pe=%0b fe=%0b brk=%0b cyc=%0d",
                                     k, get_data(k), pe[k], fe[k], brk[k], cyc,
                                     e.k, e.data, e.pe, e.fe, e.brk, e.cyc);
                        end else begin
                            $display("ok   frame dut%0d data=%h pe=%0b fe=%0b brk=%0b cyc=%0d",
                                     k, get_data(k), pe[k], fe[k], brk[k], cyc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        exp_t eb;
        int   w;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) rx_line[k] = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++)
            check($sformatf("reset_outputs_dut%0d", k),
                  {dv[k], pe[k], fe[k], brk[k], busy[k], get_data(k)}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3 * CPB) @(posedge clk);

        // Plain, parity and two-stop frames, including a bad stop and back-to-back pair
        send_frame(0, 9'h0A5, 1'b0, 2'b00, 9'h000, 2);
        send_frame(1, 9'h037, 1'b0, 2'b00, 9'h000, 2);
        send_frame(1, 9'h037, 1'b1, 2'b00, 9'h000, 2);
        send_frame(2, 9'h096, 1'b0, 2'b10, 9'h000, 2);
        send_frame(2, 9'h011, 1'b0, 2'b00, 9'h000, 0);
        send_frame(2, 9'h0EE, 1'b0, 2'b00, 9'h000, 2);

        // Short low glitch on an idle line
        hold_line(0, 1'b0, 6);
        check("glitch_busy_set", busy[0], 1);
        @(posedge clk);
        #1 rx_line[0] = 1'b1;
        for (w = 0; w < 10 && busy[0]; w++) begin
            @(posedge clk);
            #1;
        end
        check("glitch_busy_clear", busy[0], 0);
        hold_line(0, 1'b1, 2 * CPB);

        // Single-clock flips at mid-bit of every data bit
        send_frame(0, 9'h05A, 1'b0, 2'b00, 9'h0FF, 2);

        // Break: line low for 20 bit times
        eb.k = 0; eb.data = 9'h000; eb.pe = 1'b0; eb.fe = 1'b1; eb.brk = 1'b1;
        @(posedge clk);
        #1;
        eb.cyc = exp_cycle(cyc, 1 + cfg_db(0) + cfg_stop(0));
        exp_q.push_back(eb);
        rx_line[0] = 1'b0;
        hold_line(0, 1'b0, 20 * CPB - 1);
        check("break_wait_busy", busy[0], 1);
        hold_line(0, 1'b1, 2 * CPB);
        check("break_released_busy", busy[0], 0);
        send_frame(0, 9'h0C3, 1'b0, 2'b00, 9'h000, 2);

        // Reset in the middle of the data bits while the line is low
        hold_line(0, 1'b0, 4 * CPB);
        check("pre_reset_busy", busy[0], 1);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midframe_reset_outputs",
              {dv[0], pe[0], fe[0], brk[0], busy[0], get_data(0)}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        hold_line(0, 1'b0, 4 * CPB);
        check("no_restart_while_low", busy[0], 0);
        hold_line(0, 1'b1, 2 * CPB);
        send_frame(0, 9'h03C, 1'b0, 2'b00, 9'h000, 2);

        // Nine data bits with odd parity
        send_frame(3, 9'h1FF, 1'b0, 2'b00, 9'h000, 2);

        // Random frames across all configurations
        for (int r = 0; r < 24; r++) begin
            int         k;
            int         gap;
            bit         pflip;
            logic [1:0] smask;
            logic [8:0] dat;
            logic [8:0] flp;
            k     = $urandom_range(0, 3);
            dat   = 9'($urandom);
            flp   = 9'($urandom);
            pflip = (cfg_par(k) != 0) && ($urandom_range(0, 3) == 0);
            smask = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if (cfg_stop(k) == 1) smask[1] = 1'b0;
            gap = $urandom_range(0, 2);
            if (smask[cfg_stop(k) - 1] && gap == 0) gap = 1;
            send_frame(k, dat, pflip, smask, flp, gap);
        end

        hold_line(0, 1'b1, 4 * CPB);
        check("all_expected_strobes_seen", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
